fpu_add_sub_sequencer: RTL and testbench
========================================

FPU_ADD_SUB_SEQUENCER -- requirements
Module: fpu_add_sub_sequencer

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the IEEE-754 word width (32 single, 64 double).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum wait for fpu_ready, in cycles.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the upstream request ports: req_valid in 1, req_ready out 1, req_x in W, req_y in W, req_op in 1 (0 add, 1 subtract), req_rmode in 2 (rounding mode).
REQ-006 The block SHALL have the FPU-side ports: fpu_beg out 1, fpu_rst out 1, fpu_x out W, fpu_y out W, fpu_op out 1, fpu_rmode out 2, fpu_ready in 1, fpu_result in W, fpu_ovf in 1, fpu_unf in 1.
REQ-007 The block SHALL have the downstream response ports: rsp_valid out 1, rsp_ready in 1, rsp_result out W, rsp_ovf out 1, rsp_unf out 1, rsp_timeout out 1.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-009 The FSM SHALL have the states IDLE, LAUNCH, WAIT, CLEAR and RESP, each encoded as a registered state.
REQ-010 In IDLE, req_ready SHALL be 1; a req_valid&req_ready cycle SHALL latch req_x/y/op/rmode into fpu_x/y/op/rmode and go to LAUNCH.
REQ-011 req_ready SHALL be 0 in all states other than IDLE.
REQ-012 LAUNCH SHALL assert fpu_beg for exactly one cycle and then go to WAIT.
REQ-013 fpu_x/y/op/rmode SHALL hold stable from LAUNCH through the end of CLEAR.
REQ-014 In WAIT, fpu_ready=1 SHALL capture fpu_result, fpu_ovf and fpu_unf into the rsp_* registers, clear rsp_timeout, and go to CLEAR.
REQ-015 CLEAR SHALL assert fpu_rst for exactly one cycle, returning the FPU FSM to idle, and then go to RESP.
REQ-016 RESP SHALL hold rsp_valid=1 with rsp_* stable until rsp_ready=1; on that cycle it SHALL drop rsp_valid and go to IDLE.
REQ-017 Minimum latency SHALL be as follows: request accepted at cycle N, fpu_beg at N+1, fpu_ready observed at N+1+k, fpu_rst at N+2+k, rsp_valid at N+3+k.
REQ-018 There SHALL be no bypass from RESP to the next request: req_ready rises the cycle after the response handshake.
REQ-019 fpu_ready sampled while not in WAIT SHALL be ignored.
REQ-020 fpu_beg and fpu_rst SHALL never be high in the same cycle.

Reset
REQ-021 When rst is low, all outputs SHALL go asynchronously to these values: state IDLE, req_ready 0, fpu_beg 0, fpu_rst 0, fpu_x/y 0, fpu_op 0, fpu_rmode 0, rsp_valid 0, rsp_result 0, rsp_ovf/unf/timeout 0, busy 0, watchdog 0.
REQ-022 req_ready SHALL rise on the first clock edge after rst deasserts.
REQ-023 Reset during any state SHALL discard the in-flight operation, with no response emitted.

Configuration
REQ-024 With FPU_SEQ_TIMEOUT_EN defined, a watchdog SHALL count cycles in WAIT.
REQ-025 With FPU_SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYC without fpu_ready SHALL set rsp_timeout=1, rsp_result=0 and rsp_ovf/unf=0, then go to CLEAR.
REQ-026 With FPU_SEQ_TIMEOUT_EN defined, if fpu_ready=1 in the same cycle the count expires, the ready path SHALL win with timeout 0.
REQ-027 With FPU_SEQ_TIMEOUT_EN undefined, there SHALL be no counter, WAIT SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Structure
REQ-028 Package fpu_seq_pkg SHALL hold the state enum type, the W/TIMEOUT_CYC defaults and the watchdog width constant $clog2(TIMEOUT_CYC+1).
REQ-029 Sub-module fpu_seq_watchdog SHALL implement the clear/enable counter and the expire flag, instantiated only under FPU_SEQ_TIMEOUT_EN.
REQ-030 The block SHALL connect directly to the FPU adder's beg_FSM, rst_FSM, Data_X, Data_Y, add_subt, r_mode, ready, final_result_ieee, overflow_flag and underflow_flag ports.

Verification
REQ-031 The bench SHALL send x=0x3F800000 and y=0x40000000 with op=0 and an FPU model at k=5 cycles, and SHALL check one fpu_beg pulse, one fpu_rst pulse, rsp_result=0x40400000 and rsp_valid at N+8.
REQ-032 The bench SHALL send x=0x7F7FFFFF and y=0x7F7FFFFF with op=0, the model returning ovf=1, and SHALL check that rsp_ovf=1, rsp_unf=0 and the result is captured verbatim.
REQ-033 The bench SHALL hold rsp_ready=0 for 10 cycles and SHALL check that rsp_valid and rsp_result stay stable, req_ready=0, and a second req_valid is not accepted.
REQ-034 The bench SHALL run, with FPU_SEQ_TIMEOUT_EN defined and the model never raising ready, and SHALL check rsp_timeout=1 and rsp_result=0 after exactly 64 WAIT cycles, followed by fpu_rst.
REQ-035 The bench SHALL raise fpu_ready on the 64th WAIT cycle and SHALL check rsp_timeout=0 and the result captured.
REQ-036 The bench SHALL assert rst low in the middle of WAIT and SHALL check that all outputs are at reset values immediately, no rsp_valid appears, and req_ready=1 one cycle after release.

Source files
------------

// File: rtl/fpu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_seq_pkg
//  Description : Shared types and constants for the FPU add/subtract
//                sequencer: sequencer state encoding, default word width,
//                default watchdog limit and the watchdog counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_seq_pkg;

    localparam int c_DEFAULT_W           = 32;
    localparam int c_DEFAULT_TIMEOUT_CYC = 64;

    // Watchdog counter width for a given limit; the +1 keeps the limit itself
    // representable when it is an exact power of two.
    function automatic int wdog_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

    localparam int c_WDOG_W = $clog2(c_DEFAULT_TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_RESP   = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_seq_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_seq_watchdog
//  Description : Cycle counter with synchronous clear and count enable.
//                expire is high during the TIMEOUT_CYC-th consecutive enabled
//                cycle since the last clear.
//  Ports       : clk    - clock (rising edge)
//                rst    - asynchronous reset, active low
//                clr    - synchronous clear of the count
//                en     - count enable
//                expire - limit reached in the current cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_seq_watchdog #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The first enabled cycle sees a count of 0, so the limit-th one sees LAST.
    assign expire = en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fpu_add_sub_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_add_sub_sequencer
//  Description : Drives one FPU add/subtract operation per request: latches
//                the operands, pulses fpu_beg, waits for fpu_ready, captures
//                result and flags, pulses fpu_rst to return the FPU to idle,
//                then holds the response until rsp_ready.
//  Ports       : clk/rst            - clock, asynchronous active-low reset
//                req_*              - upstream valid/ready request
//                fpu_*              - FPU adder control, operands and results
//                rsp_*              - downstream valid/ready response
//                busy               - high whenever not idle
//  Config      : FPU_SEQ_TIMEOUT_EN - enables the WAIT watchdog; without it
//                the sequencer waits for fpu_ready indefinitely and
//                rsp_timeout is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_add_sub_sequencer
    import fpu_seq_pkg::*;
#(
    parameter int W           = c_DEFAULT_W,
    parameter int TIMEOUT_CYC = c_DEFAULT_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_x,
    input  logic [W-1:0] req_y,
    input  logic         req_op,
    input  logic [1:0]   req_rmode,
    output logic         fpu_beg,
    output logic         fpu_rst,
    output logic [W-1:0] fpu_x,
    output logic [W-1:0] fpu_y,
    output logic         fpu_op,
    output logic [1:0]   fpu_rmode,
    input  logic         fpu_ready,
    input  logic [W-1:0] fpu_result,
    input  logic         fpu_ovf,
    input  logic         fpu_unf,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_result,
    output logic         rsp_ovf,
    output logic         rsp_unf,
    output logic         rsp_timeout,
    output logic         busy
);

    localparam int c_WDOG_W = wdog_width(TIMEOUT_CYC);

    seq_state_t   r_state;
    logic         r_req_ready;
    logic         r_fpu_beg;
    logic         r_fpu_rst;
    logic [W-1:0] r_fpu_x;
    logic [W-1:0] r_fpu_y;
    logic         r_fpu_op;
    logic [1:0]   r_fpu_rmode;
    logic         r_rsp_valid;
    logic [W-1:0] r_rsp_result;
    logic         r_rsp_ovf;
    logic         r_rsp_unf;
    logic         r_busy;
    logic         w_expire;

`ifdef FPU_SEQ_TIMEOUT_EN
    logic r_rsp_timeout;
    logic w_wdog_en;
    logic w_wdog_clr;

    // Count only while waiting; any other state restarts the count.
    assign w_wdog_en  = (r_state == ST_WAIT);
    assign w_wdog_clr = (r_state != ST_WAIT);

    fpu_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (c_WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_wdog_clr),
        .en     (w_wdog_en),
        .expire (w_expire)
    );

    assign rsp_timeout = r_rsp_timeout;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^c_WDOG_W;
    assign w_expire     = 1'b0;
    assign rsp_timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_fpu_beg    <= 1'b0;
            r_fpu_rst    <= 1'b0;
            r_fpu_x      <= '0;
            r_fpu_y      <= '0;
            r_fpu_op     <= 1'b0;
            r_fpu_rmode  <= 2'b00;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_unf    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // req_ready comes up one cycle after reset release.
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    if (req_valid && r_req_ready) begin
                        r_fpu_x     <= req_x;
                        r_fpu_y     <= req_y;
                        r_fpu_op    <= req_op;
                        r_fpu_rmode <= req_rmode;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_fpu_beg   <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_fpu_beg <= 1'b0;
                    r_state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A ready in the expiry cycle takes precedence.
                    if (fpu_ready) begin
                        r_rsp_result <= fpu_result;
                        r_rsp_ovf    <= fpu_ovf;
                        r_rsp_unf    <= fpu_unf;
`ifdef FPU_SEQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        r_fpu_rst    <= 1'b1;
                        r_state      <= ST_CLEAR;
                    end else if (w_expire) begin
                        r_rsp_result <= '0;
                        r_rsp_ovf    <= 1'b0;
                        r_rsp_unf    <= 1'b0;
`ifdef FPU_SEQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b1;
`endif
                        r_fpu_rst    <= 1'b1;
                        r_state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_fpu_rst   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_fpu_beg   <= 1'b0;
                    r_fpu_rst   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign fpu_beg    = r_fpu_beg;
    assign fpu_rst    = r_fpu_rst;
    assign fpu_x      = r_fpu_x;
    assign fpu_y      = r_fpu_y;
    assign fpu_op     = r_fpu_op;
    assign fpu_rmode  = r_fpu_rmode;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_unf    = r_rsp_unf;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_sub_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_add_sub_sequencer
//  Description : Self-checking bench for fpu_add_sub_sequencer. A behavioural
//                FPU answers each fpu_beg after k cycles; expected responses,
//                latencies and pulse counts come from that model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_add_sub_sequencer;

    localparam int W  = 32;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_x = '0;
    logic [W-1:0] req_y = '0;
    logic         req_op = 1'b0;
    logic [1:0]   req_rmode = 2'b00;
    logic         fpu_beg;
    logic         fpu_rst;
    logic [W-1:0] fpu_x;
    logic [W-1:0] fpu_y;
    logic         fpu_op;
    logic [1:0]   fpu_rmode;
    logic         fpu_ready;
    logic [W-1:0] fpu_result;
    logic         fpu_ovf;
    logic         fpu_unf;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_ovf;
    logic         rsp_unf;
    logic         rsp_timeout;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // FPU model controls and observations
    int           m_k = 1;
    logic [W-1:0] m_result = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;
    logic         m_never = 1'b0;
    logic         m_force = 1'b0;
    logic         mdl_ready;
    int           rem;
    int           n_beg;
    int           n_rst;
    int           last_rst_cyc;
    logic [W-1:0] x_at_rst;

    assign fpu_ready = mdl_ready | m_force;

    fpu_add_sub_sequencer #(.W(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_op(req_op), .req_rmode(req_rmode),
        .fpu_beg(fpu_beg), .fpu_rst(fpu_rst), .fpu_x(fpu_x), .fpu_y(fpu_y),
        .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_ready(fpu_ready),
        .fpu_result(fpu_result), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural FPU: ready k cycles after the fpu_beg cycle, held until fpu_rst.
    initial begin
        mdl_ready = 1'b0; fpu_result = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
        rem = 0; n_beg = 0; n_rst = 0; last_rst_cyc = -1; x_at_rst = '0;
        forever begin
            tick();
            if (!rst) begin
                rem = 0;
                mdl_ready = 1'b0;
            end else begin
                check("beg_rst_exclusive", 64'(fpu_beg & fpu_rst), 64'd0);
                if (fpu_rst) begin
                    n_rst++;
                    last_rst_cyc = cyc;
                    x_at_rst = fpu_x;
                    mdl_ready = 1'b0;
                end
                if (rem > 0) begin
                    rem--;
                    if (rem == 0) begin
                        mdl_ready  = 1'b1;
                        fpu_result = m_result;
                        fpu_ovf    = m_ovf;
                        fpu_unf    = m_unf;
                    end
                end
                if (fpu_beg) begin
                    n_beg++;
                    if (!m_never) rem = m_k;
                end
            end
        end
    end

    // One full transaction. k is the FPU latency (or the watchdog limit when
    // to_exp is set); hold is the number of cycles rsp_ready is kept low.
    task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                           input logic [1:0] rm, input int k, input logic [W-1:0] res,
                           input logic ovf, input logic unf, input logic to_exp, input int hold);
        int n, b0, r0, waited;
        logic [W-1:0] exp_res;
        m_k = k; m_result = res; m_ovf = ovf; m_unf = unf;
        b0 = n_beg; r0 = n_rst;
        exp_res = to_exp ? '0 : res;
        waited = 0;
        while (!req_ready && waited < 20) begin tick(); waited++; end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_x = x; req_y = y; req_op = op; req_rmode = rm; req_valid = 1'b1;
        n = cyc;
        tick();
        req_valid = 1'b0;
        check("launch_beg", 64'(fpu_beg), 64'd1);
        check("launch_busy", 64'(busy), 64'd1);
        check("launch_req_ready", 64'(req_ready), 64'd0);
        check("launch_fpu_x", 64'(fpu_x), 64'(x));
        check("launch_fpu_y", 64'(fpu_y), 64'(y));
        check("launch_fpu_op", 64'(fpu_op), 64'(op));
        check("launch_fpu_rmode", 64'(fpu_rmode), 64'(rm));
        waited = 0;
        while (!rsp_valid && waited < 300) begin tick(); waited++; end
        check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        check("rsp_latency", 64'(cyc - n), 64'(k + 3));
        check("fpu_rst_latency", 64'(last_rst_cyc - n), 64'(k + 2));
        check("fpu_x_stable_clear", 64'(x_at_rst), 64'(x));
        check("rsp_result", 64'(rsp_result), 64'(exp_res));
        check("rsp_ovf", 64'(rsp_ovf), 64'(to_exp ? 1'b0 : ovf));
        check("rsp_unf", 64'(rsp_unf), 64'(to_exp ? 1'b0 : unf));
        check("rsp_timeout", 64'(rsp_timeout), 64'(to_exp));
        if (hold > 0) begin
            req_valid = 1'b1; req_x = ~x;
            for (int i = 0; i < hold; i++) begin
                tick();
                check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
                check("hold_rsp_result", 64'(rsp_result), 64'(exp_res));
                check("hold_req_ready", 64'(req_ready), 64'd0);
            end
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
        check("post_busy", 64'(busy), 64'd0);
        check("beg_pulses", 64'(n_beg - b0), 64'd1);
        check("rst_pulses", 64'(n_rst - r0), 64'd1);
    endtask

    initial begin
        int seen;
        #2 rst = 1'b0;
        #1;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_fpu_beg", 64'(fpu_beg), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("req_ready_before_edge", 64'(req_ready), 64'd0);
        tick();
        check("req_ready_after_release", 64'(req_ready), 64'd1);

        // 1.0 + 2.0 = 3.0 with a 5-cycle FPU, response held back 10 cycles
        run_txn(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00, 5, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 10);
        // MAX + MAX overflows; result passed through as reported
        run_txn(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 2'b00, 3, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 0);

        // fpu_ready while idle must not start anything
        m_force = 1'b1;
        repeat (3) begin
            tick();
            check("idle_ready_busy", 64'(busy), 64'd0);
            check("idle_ready_rsp_valid", 64'(rsp_valid), 64'd0);
        end
        m_force = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_txn($urandom, $urandom, 1'($urandom), 2'($urandom), $urandom_range(1, 12),
                    $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    $urandom_range(0, 3));
        end

`ifdef FPU_SEQ_TIMEOUT_EN
        m_never = 1'b1;
        run_txn(32'h1234_5678, 32'h0BAD_F00D, 1'b1, 2'b01, TO, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 0);
        m_never = 1'b0;
        run_txn(32'h4120_0000, 32'h3F80_0000, 1'b1, 2'b10, TO, 32'h4110_0000, 1'b0, 1'b1, 1'b0, 0);
`else
        run_txn(32'h4120_0000, 32'h3F80_0000, 1'b1, 2'b10, TO, 32'h4110_0000, 1'b0, 1'b1, 1'b0, 0);
        run_txn(32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, 2'b11, 100, 32'h600D_CAFE, 1'b0, 0, 1'b0, 0);
`endif

        // Reset in the middle of WAIT
        m_k = 20;
        req_x = 32'hCAFE_0001; req_y = 32'h0000_BEEF; req_op = 1'b1; req_rmode = 2'b11;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        check("mid_wait_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_fpu_beg", 64'(fpu_beg), 64'd0);
        check("arst_fpu_rst", 64'(fpu_rst), 64'd0);
        check("arst_fpu_x", 64'(fpu_x), 64'd0);
        check("arst_fpu_y", 64'(fpu_y), 64'd0);
        check("arst_fpu_op", 64'(fpu_op), 64'd0);
        check("arst_fpu_rmode", 64'(fpu_rmode), 64'd0);
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_rsp_result", 64'(rsp_result), 64'd0);
        check("arst_rsp_ovf", 64'(rsp_ovf), 64'd0);
        check("arst_rsp_unf", 64'(rsp_unf), 64'd0);
        check("arst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rearm_req_ready_before_edge", 64'(req_ready), 64'd0);
        tick();
        check("rearm_req_ready", 64'(req_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", 64'(seen), 64'd0);
        check("idle_after_reset", 64'(busy), 64'd0);

        run_txn(32'h3F80_0000, 32'h3F80_0000, 1'b1, 2'b00, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
